// File: rtl/synth_pkg.sv
// Shared constants and types for the synth audio path (generator and demodulator).
package synth_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int PWM_PERIOD = 1 << SAMPLE_W;

  typedef enum logic {
    IDLE,
    MEASURE
  } demod_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rising-edge detect for asynchronous single-bit inputs.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s2_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s2_prev_q <= 1'b0;
    end else begin
      s1_q      <= d_i;
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s2_prev_q;

endmodule

// File: rtl/pwm_audio_demod.sv
// Recovers one PCM sample per PWM frame by timing the high portion between rising edges,
// and flags stuck lines and off-period frames.
module pwm_audio_demod #(
  parameter int SAMPLE_W = synth_pkg::SAMPLE_W,
  parameter int PERIOD   = synth_pkg::PWM_PERIOD,
  parameter int TOL      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ena_i,
  input  logic                pwm_in_i,
  output logic [SAMPLE_W-1:0] sample_out_o,
  output logic                sample_valid_o,
  output logic                stuck_o,
  output logic                period_err_o
);
  import synth_pkg::*;

  localparam int CNT_W = $clog2(2 * PERIOD) + 1;
  localparam logic [CNT_W-1:0] SAT_CNT      = CNT_W'((1 << SAMPLE_W) - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(2 * PERIOD - 1);
  localparam logic [CNT_W-1:0] PER_MIN      = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] PER_MAX      = CNT_W'(PERIOD + TOL);
  localparam logic [SAMPLE_W-1:0] SAT_SAMPLE = SAT_CNT[SAMPLE_W-1:0];

  logic level;
  logic rise;

  sync_edge u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (pwm_in_i),
    .level_o (level),
    .rise_o  (rise)
  );

  demod_state_e        state_q, state_d;
  logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]    high_cnt_q, high_cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                stuck_q, stuck_d;
  logic                err_q, err_d;

  // Timeout fires on the cycle the period count would reach 2*PERIOD, so strobes
  // repeat exactly every 2*PERIOD clocks; a coincident rise takes priority.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    stuck_d      = stuck_q;
    if (!ena_i) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          if (rise) begin
            state_d      = MEASURE;
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            sample_d     = (high_cnt_q > SAT_CNT) ? SAT_SAMPLE : high_cnt_q[SAMPLE_W-1:0];
            valid_d      = 1'b1;
            err_d        = (period_cnt_q < PER_MIN) || (period_cnt_q > PER_MAX);
            stuck_d      = 1'b0;
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
          end else if (period_cnt_q == TIMEOUT_LAST) begin
            sample_d     = level ? SAT_SAMPLE : '0;
            valid_d      = 1'b1;
            stuck_d      = 1'b1;
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + CNT_W'(1);
            if (level) begin
              high_cnt_d = high_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      err_q        <= err_d;
    end
  end

  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign stuck_o        = stuck_q;
  assign period_err_o   = err_q;

endmodule

// File: tb/tb_pwm_audio_demod.sv
// Randomized scoreboard bench for pwm_audio_demod, run at a reduced frame size so
// stuck-line timeouts fit in a short simulation.
module tb_pwm_audio_demod;

  localparam int SW   = 8;
  localparam int PER  = 1 << SW;
  localparam int TOLB = 8;
  localparam int TMO  = 2 * PER;
  localparam int SATV = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          pwm = 1'b0;
  logic [SW-1:0] sampleOut;
  logic          sampleValid;
  logic          stuck;
  logic          periodErr;

  pwm_audio_demod #(
    .SAMPLE_W (SW),
    .PERIOD   (PER),
    .TOL      (TOLB)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ena_i          (ena),
    .pwm_in_i       (pwm),
    .sample_out_o   (sampleOut),
    .sample_valid_o (sampleValid),
    .stuck_o        (stuck),
    .period_err_o   (periodErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int sample;
    bit err;
    bit stuck;
  } exp_t;

  exp_t expQ[$];
  exp_t expItem;
  bit   expNow;
  int   compared   = 0;
  int   mismatched = 0;
  int   cycleCount = 0;
  bit   lineHist[int];

  // Reference model state, kept in line time (the clock on which the bench drove pwm).
  bit measuring     = 1'b0;
  bit anchorTimeout = 1'b0;
  int anchor        = 0;
  int nextTimeout   = 0;
  bit mStuck        = 1'b0;
  int mSample       = 0;
  bit prevLevel     = 1'b0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycleCount);
    end
  endtask

  function automatic int highCount(input int a, input int b);
    int n = 0;
    for (int j = a; j < b; j++) begin
      if (lineHist.exists(j) && lineHist[j]) n++;
    end
    return n;
  endfunction

  // A completed frame spans from the previous anchor to this rise; after a timeout the
  // counters restart from zero on the cycle following the timeout.
  task automatic modelRise(input int r);
    int period;
    int high;
    int dev;
    if (!ena) begin
      measuring = 1'b0;
      return;
    end
    if (measuring) begin
      if (anchorTimeout) begin
        period = r - anchor - 1;
        high   = highCount(anchor + 1, r);
      end else begin
        period = r - anchor;
        high   = highCount(anchor, r);
      end
      dev     = (period > PER) ? period - PER : PER - period;
      mSample = (high > SATV) ? SATV : high;
      mStuck  = 1'b0;
      expQ.push_back('{r + 3, mSample, (dev > TOLB), 1'b0});
    end
    measuring     = 1'b1;
    anchor        = r;
    anchorTimeout = 1'b0;
    nextTimeout   = r + TMO - 1;
  endtask

  task automatic applyStimulus(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pwm = v;
      lineHist[cycleCount] = v;
      if (v && !prevLevel) begin
        modelRise(cycleCount);
      end else if (measuring && ena && cycleCount == nextTimeout) begin
        mSample       = v ? SATV : 0;
        mStuck        = 1'b1;
        expQ.push_back('{cycleCount + 3, mSample, 1'b0, 1'b1});
        anchor        = cycleCount;
        anchorTimeout = 1'b1;
        nextTimeout   = cycleCount + TMO;
      end
      prevLevel = v;
    end
  endtask

  task automatic applyFrame(input int h, input int l);
    applyStimulus(1'b1, h);
    applyStimulus(1'b0, l);
  endtask

  task automatic applyEna(input bit v);
    ena = v;
    if (!v) measuring = 1'b0;
    checkOutput("sample_out hold", sampleOut, mSample);
    checkOutput("stuck hold", stuck, mStuck);
  endtask

  task automatic applyReset();
    checkOutput("pending before reset", expQ.size(), 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("reset sample_out", sampleOut, 0);
    checkOutput("reset sample_valid", sampleValid, 0);
    checkOutput("reset stuck", stuck, 0);
    checkOutput("reset period_err", periodErr, 0);
    measuring = 1'b0;
    mStuck    = 1'b0;
    mSample   = 0;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Any strobe must match the head of the queue in cycle and content.
  always @(negedge clk) begin
    if (!rst) begin
      expNow = (expQ.size() > 0) && (expQ[0].cyc == cycleCount);
      checkOutput("sample_valid", sampleValid, expNow);
      if (expNow) begin
        expItem = expQ.pop_front();
        checkOutput("sample_out", sampleOut, expItem.sample);
        checkOutput("period_err", periodErr, expItem.err);
        checkOutput("stuck", stuck, expItem.stuck);
      end else begin
        checkOutput("period_err quiet", periodErr, 0);
        if (expQ.size() > 0 && expQ[0].cyc < cycleCount) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int len;
    int h;
    applyReset();
    applyStimulus(1'b0, 5);

    $display("[TB] steady duty");
    repeat (10) applyFrame(100, PER - 100);

    $display("[TB] extremes and saturation");
    repeat (3) applyFrame(1, PER - 1);
    repeat (3) applyFrame(PER - 1, 1);
    applyFrame(300, 10);
    applyFrame(100, PER - 100);

    $display("[TB] period tolerance");
    applyFrame(100, PER + 4 - 100);
    applyFrame(100, PER + TOLB - 100);
    applyFrame(100, PER + TOLB + 1 - 100);
    applyFrame(100, PER - TOLB - 100);
    applyFrame(100, PER - TOLB - 1 - 100);
    applyFrame(100, PER + 44 - 100);
    applyFrame(100, PER - 100);

    $display("[TB] random frames");
    for (int i = 0; i < 20; i++) begin
      len = PER + $urandom_range(0, 2 * TOLB + 4) - (TOLB + 2);
      h   = $urandom_range(1, len - 1);
      applyFrame(h, len - h);
    end

    $display("[TB] stuck low");
    applyFrame(125, PER - 125);
    applyStimulus(1'b0, 2 * TMO + 300);
    applyFrame(100, PER - 100);
    applyFrame(100, PER - 100);

    $display("[TB] stuck high then reset");
    applyStimulus(1'b1, TMO + 200);
    applyStimulus(1'b0, 50);
    applyReset();
    applyStimulus(1'b0, 10);
    repeat (3) applyFrame(90, PER - 90);

    $display("[TB] enable drop");
    repeat (2) applyFrame(80, PER - 80);
    applyStimulus(1'b1, 80);
    applyStimulus(1'b0, 60);
    applyEna(1'b0);
    applyStimulus(1'b0, PER - 140);
    repeat (2) applyFrame(80, PER - 80);
    applyStimulus(1'b1, 80);
    applyStimulus(1'b0, 60);
    applyEna(1'b1);
    applyStimulus(1'b0, PER - 140);
    repeat (3) applyFrame(70, PER - 70);

    applyStimulus(1'b0, 10);
    checkOutput("pending at end", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
